// File: rtl/stereo_pkg.sv
// Shared constants for the register-slice pipeline.
// Holds the stage-count ceiling and the occupancy-counter width helper.
package stereo_pkg;

  localparam int MAX_DEPTH = 16;

  // Zero-width ports are illegal, so DEPTH=0 still gets a 1-bit counter.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One skid stage: main register plus a single skid register.
// Upstream ready is a flop, so no ready path passes through the stage.
module pipe_skid_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_fire  = valid_i & rdy_q;
  assign out_fire = main_v_q & ready_i;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (out_fire) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (in_fire) begin
        main_d = data_i;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_fire) begin
      // A stalled main forces the in-flight beat into the skid slot.
      if (main_v_q) begin
        skid_v_d = 1'b1;
        skid_d   = data_i;
      end else begin
        main_v_d = 1'b1;
        main_d   = data_i;
      end
    end
    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign ready_o = rdy_q;
  assign valid_o = main_v_q;
  assign data_o  = main_q;

endmodule

// File: rtl/pipe_reg_slice.sv
// Chain of DEPTH skid stages; DEPTH=0 is a pure wire-through.
// Optional PIPE_REG_SLICE_OCCUPANCY_EN adds a stored-beat counter port.
module pipe_reg_slice
  import stereo_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  localparam int N = (DEPTH > MAX_DEPTH) ? MAX_DEPTH : DEPTH;

  generate
    if (N == 0) begin : g_wire
      assign outp       = inp;
      assign outp_valid = inp_valid;
      assign inp_ready  = outp_ready;
    end else begin : g_chain
      logic             sv [N];
      logic             sr [N];
      logic [WIDTH-1:0] sd [N];
      for (genvar i = 0; i < N; i++) begin : g_stage
        logic             vin, rin;
        logic [WIDTH-1:0] din;
        if (i == 0) begin : g_head
          assign vin = inp_valid;
          assign din = inp;
        end else begin : g_mid
          assign vin = sv[i-1];
          assign din = sd[i-1];
        end
        if (i == N - 1) begin : g_tail
          assign rin = outp_ready;
        end else begin : g_body
          assign rin = sr[i+1];
        end
        pipe_skid_stage #(.WIDTH(WIDTH)) u_stage (
          .clk     (clk),
          .rst     (rst),
          .valid_i (vin),
          .ready_o (sr[i]),
          .data_i  (din),
          .valid_o (sv[i]),
          .ready_i (rin),
          .data_o  (sd[i])
        );
      end
      assign inp_ready  = sr[0];
      assign outp_valid = sv[N-1];
      assign outp       = sd[N-1];
    end
  endgenerate

`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
  localparam int OW = occ_width(DEPTH);
  logic [OW-1:0] occ_q, occ_d;
  logic          in_acc, out_acc;

  assign in_acc  = inp_valid & inp_ready;
  assign out_acc = outp_valid & outp_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_acc && !out_acc) begin
      occ_d = occ_q + OW'(1);
    end else if (!in_acc && out_acc) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Randomised and directed bench for pipe_reg_slice (DEPTH=3 and DEPTH=0).
// Reference model is an in-order queue of accepted beats.
module tb_pipe_reg_slice;
  import stereo_pkg::*;

  localparam int D = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv, ir, ov, ordy;
  logic [W-1:0] id, od;
  logic         ziv, zir, zov, zordy;
  logic [W-1:0] zid, zod;
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
  logic [occ_width(D)-1:0] occ;
  logic [occ_width(0)-1:0] zocc;
`endif

  always #5 clk = ~clk;

  pipe_reg_slice #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .inp_valid  (iv),
    .inp_ready  (ir),
    .inp        (id),
    .outp_valid (ov),
    .outp_ready (ordy),
    .outp       (od)
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
    ,
    .occupancy  (occ)
`endif
  );

  pipe_reg_slice #(.WIDTH(W), .DEPTH(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .inp_valid  (ziv),
    .inp_ready  (zir),
    .inp        (zid),
    .outp_valid (zov),
    .outp_ready (zordy),
    .outp       (zod)
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
    ,
    .occupancy  (zocc)
`endif
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           nin = 0;
  int           nout = 0;
  int           first_acc, first_ov, last_ov;
  logic [W-1:0] q[$];
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_d;
  logic         last_ir;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, settle, compare against the queue model.
  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic r);
    @(negedge clk);
    iv = v;
    id = d;
    ordy = r;
    #1;
    cyc++;
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
    chk("occ_model", 32'(occ), q.size());
`endif
    if (hold_pend) begin
      chk("hold_valid", ov, 1);
      chk("hold_data", od, hold_d);
    end
    if (ov) begin
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
    end
    if (ov && ordy) begin
      if (q.size() == 0) chk("spurious_ov", ov, 0);
      else chk("order", od, q.pop_front());
      nout++;
    end
    if (iv && ir) begin
      if (first_acc < 0) first_acc = cyc;
      q.push_back(id);
      nin++;
    end
    hold_pend = ov && !ordy;
    hold_d = od;
    last_ir = ir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iv = 1'b1;
    id = 8'hEE;
    ordy = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ov", ov, 0);
    chk("rst_od", od, 0);
    chk("rst_ir", ir, 0);
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
    chk("rst_occ", 32'(occ), 0);
`endif
    rst = 1'b0;
    iv = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ir", ir, 1);
    q.delete();
    hold_pend = 1'b0;
  endtask

  initial begin
    int n0, i0, got;
    iv = 0; id = 0; ordy = 0;
    ziv = 0; zid = 0; zordy = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Back-to-back stream, downstream never stalled
    first_acc = -1; first_ov = -1; last_ov = -1; n0 = nout;
    for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);
    chk("thru_cnt", nout - n0, 10);
    chk("latency", first_ov - first_acc, D);
    chk("no_bubble", last_ov - first_ov, 9);

    // Fill with downstream stalled
    n0 = nin;
    repeat (12) step(1'b1, W'($urandom), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("fill_cnt", nin - n0, 2 * D);
    chk("full_ir", last_ir, 0);
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
    chk("full_occ", 32'(occ), 2 * D);
`endif

    // Drain: ready must come back within a bounded number of cycles
    step(1'b0, '0, 1'b1);
    got = 0;
    for (int j = 0; j < D + 1 && got == 0; j++) begin
      step(1'b0, '0, 1'b1);
      if (last_ir) got = 1;
    end
    chk("ready_back", got, 1);
    repeat (10) step(1'b0, '0, 1'b1);
    chk("drain_empty", q.size(), 0);

    // Random valid/ready, 1000 beats
    n0 = nout; i0 = nin;
    for (int k = 0; k < 20000 && nout - n0 < 1000; k++) begin
      step((nin - i0 < 1000) ? 1'($urandom % 2) : 1'b0,
           W'($urandom), 1'($urandom % 2));
    end
    chk("rand_cnt", nout - n0, 1000);
    chk("rand_empty", q.size(), 0);

    // Reset with 4 beats stored
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hA0 + i), 1'b0);
    chk("stored4", q.size(), 4);
    do_reset();
    n0 = nout;
    repeat (8) step(1'b0, '0, 1'b1);
    chk("no_ghost", nout - n0, 0);

    // DEPTH=0 pass-through
    @(negedge clk);
    zid = 8'h5A; ziv = 1'b1; zordy = 1'b1;
    #1;
    chk("z_od", zod, 8'h5A);
    chk("z_ov", zov, 1);
    chk("z_ir_hi", zir, 1);
    zordy = 1'b0;
    #1;
    chk("z_ir_lo", zir, 0);
    ziv = 1'b0;
    #1;
    chk("z_ov_lo", zov, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ziv = 1'($urandom % 2);
      zordy = 1'($urandom % 2);
      zid = W'($urandom);
      #1;
      chk("z_rand_d", zod, zid);
      chk("z_rand_v", zov, ziv);
      chk("z_rand_r", zir, zordy);
    end
`ifdef PIPE_REG_SLICE_OCCUPANCY_EN
    chk("z_occ", 32'(zocc), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
